// File: rtl/vq6_pkg.sv
// vq6_pkg
// Shared definitions for the 6-element vector-quantizer loop-state block:
// element count, sorter address width, default accumulator width and
// midscale value, and the input-code clamp helper.
package vq6_pkg;

   localparam int NUM_EL        = 6;
   localparam int ADDR_W        = 3;
   localparam int STATE_W_DEF   = 8;
   localparam int RST_STATE_DEF = 128;

   // Codes 0..6 pass through; the only out-of-range 3-bit code (7) maps to 6.
   function automatic logic [ADDR_W-1:0] clamp_code(input logic [ADDR_W-1:0] code);
      return (code > 3'd6) ? 3'd6 : code;
   endfunction

endpackage

// File: rtl/vq6_rank_decode.sv
// vq6_rank_decode
// Purely combinational rank-to-element decode. The sorter reports, for each
// rank k (5 = largest state, 0 = smallest), the address of the element that
// holds it. The top c ranks are selected and their addresses are turned into
// a one-bit-per-element enable.
// Ports:
//   c  in   clamped code, 0..6 (number of elements to enable)
//   b  in   sorter addresses, b[k] is the element address at rank k
//   e  out  per-element enable, bit i = element i selected
// Addresses 6 and 7 match no element, so they select nothing; duplicate
// addresses are used as given.
module vq6_rank_decode
   import vq6_pkg::*;
(
   input  logic [ADDR_W-1:0]             c,
   input  logic [NUM_EL-1:0][ADDR_W-1:0] b,
   output logic [NUM_EL-1:0]             e
);

   logic [NUM_EL-1:0] rank_sel;

   genvar gi, gk;
   generate
      // Rank k is selected when k >= 6 - c, rewritten as k + c >= 6 to stay unsigned.
      for (gk = 0; gk < NUM_EL; gk++) begin : g_rank
         assign rank_sel[gk] = ((4'(gk) + {1'b0, c}) >= 4'(NUM_EL));
      end

      for (gi = 0; gi < NUM_EL; gi++) begin : g_el
         logic [NUM_EL-1:0] hit;
         for (gk = 0; gk < NUM_EL; gk++) begin : g_hit
            assign hit[gk] = rank_sel[gk] && (b[gk] == ADDR_W'(gi));
         end
         assign e[gi] = |hit;
      end
   endgenerate

endmodule

// File: rtl/vq6_loop_state.sv
// vq6_loop_state
// Loop-filter state and element selection for the 6-element VQ mismatch
// shaper. Six accumulators feed an external sorter; the sorter's address
// vector comes back, the top c ranks are enabled, and each accumulator moves
// by c - 6*e_i per valid sample (total state is conserved).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid       a sample is present this cycle
//   in_code        elements to enable, 0..6 (7 treated as 6)
//   b5..b0         sorter addresses, b5 = largest state, b0 = smallest
//   st5..st0       accumulator states, wired straight to the sorter inputs
//   sel            registered element enable, bit i drives unit element i
//   out_valid      sel was loaded from a valid sample on the last edge
//   ovf            sticky saturation flag (only with VQ6_SAT_EN)
// Build option: define VQ6_SAT_EN to saturate the accumulators to
// [0, 2^STATE_W-1] and add the ovf port; otherwise updates wrap.
module vq6_loop_state
   import vq6_pkg::*;
#(
   parameter int STATE_W   = STATE_W_DEF,
   parameter int RST_STATE = RST_STATE_DEF
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [2:0]         in_code,
   input  logic [2:0]         b5,
   input  logic [2:0]         b4,
   input  logic [2:0]         b3,
   input  logic [2:0]         b2,
   input  logic [2:0]         b1,
   input  logic [2:0]         b0,
   output logic [STATE_W-1:0] st5,
   output logic [STATE_W-1:0] st4,
   output logic [STATE_W-1:0] st3,
   output logic [STATE_W-1:0] st2,
   output logic [STATE_W-1:0] st1,
   output logic [STATE_W-1:0] st0,
   output logic [5:0]         sel,
   output logic               out_valid
`ifdef VQ6_SAT_EN
   ,
   output logic               ovf
`endif
);

   localparam logic [STATE_W-1:0] RST_VAL = STATE_W'(RST_STATE);

   logic [ADDR_W-1:0]             c;
   logic [NUM_EL-1:0][ADDR_W-1:0] b_vec;
   logic [NUM_EL-1:0]             e;
   logic [STATE_W-1:0]            st_all [NUM_EL];

   assign c     = clamp_code(in_code);
   assign b_vec = {b5, b4, b3, b2, b1, b0};

   vq6_rank_decode u_rank_decode (
      .c (c),
      .b (b_vec),
      .e (e)
   );

`ifdef VQ6_SAT_EN
   localparam int W3 = STATE_W + 3;
   logic [NUM_EL-1:0] clip;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_EL; gi++) begin : g_el
         logic [STATE_W-1:0] st_reg;
         logic [STATE_W-1:0] st_next;

`ifdef VQ6_SAT_EN
         // Signed headroom: the update spans -6..+6 around an unsigned state.
         logic signed [W3-1:0] sum;
         assign sum = $signed(W3'(st_reg)) + $signed(W3'(c))
                    - (e[gi] ? $signed(W3'(6)) : $signed(W3'(0)));

         always_comb begin
            st_next  = sum[STATE_W-1:0];
            clip[gi] = 1'b0;
            if (sum < 0) begin
               st_next  = '0;
               clip[gi] = 1'b1;
            end else if (sum > $signed(W3'({STATE_W{1'b1}}))) begin
               st_next  = '1;
               clip[gi] = 1'b1;
            end
         end
`else
         // Modulo 2^STATE_W: the low bits of the wide signed sum equal this.
         assign st_next = st_reg + STATE_W'(c) - (e[gi] ? STATE_W'(6) : '0);
`endif

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               st_reg <= RST_VAL;
            end else if (in_valid) begin
               st_reg <= st_next;
            end
         end

         assign st_all[gi] = st_reg;
      end
   endgenerate

   assign st5 = st_all[5];
   assign st4 = st_all[4];
   assign st3 = st_all[3];
   assign st2 = st_all[2];
   assign st1 = st_all[1];
   assign st0 = st_all[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sel <= e;
         end
      end
   end

`ifdef VQ6_SAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (in_valid && (|clip)) begin
         ovf <= 1'b1;
      end
   end
`endif

endmodule
